weight_stream_sink: RTL
=======================

# weight_stream_sink

- Receiving end of the weight-source stream protocol.
- Accepts a weight tensor as a sequence of valid/ready beats of `WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1` elements, writes each beat into an internal buffer, and flags when the full tensor has landed.
- Exposes the buffer through a 2-cycle registered read port with the same timing as the parameter ROMs, so downstream compute can swap a ROM for a runtime-loadable buffer.
- Sits between a host/DMA stream and a linear layer's weight port.

## Interface
Parameters:
- WEIGHT_TENSOR_SIZE_DIM_0, 32, tensor elements along dim 0
- WEIGHT_TENSOR_SIZE_DIM_1, 1, tensor elements along dim 1
- WEIGHT_PRECISION_0, 16, element width in bits
- WEIGHT_PRECISION_1, 3, fractional bits (informational, not used in logic)
- WEIGHT_PARALLELISM_DIM_0, 1, elements per beat along dim 0
- WEIGHT_PARALLELISM_DIM_1, 1, elements per beat along dim 1
- IN_DEPTH, (DIM_0*DIM_1)/(PAR_0*PAR_1), beats per tensor; must be ≥2

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, asynchronous assert, active-low; release is synchronised internally by a 2-flop deassert synchroniser
- data_in  in  [WEIGHT_PRECISION_0-1:0] x P  one beat, where P = PAR_0*PAR_1; element j occupies bits [W*j+W-1:W*j] of the stored word, with W = WEIGHT_PRECISION_0
- data_in_valid  in  1  beat valid
- data_in_ready  out  1  sink can accept
- release  in  1  single-cycle pulse; consumer has finished with the buffered tensor
- tensor_done  out  1  full tensor resident in buffer
- rd_addr  in  $clog2(IN_DEPTH)+1  read word address
- rd_ce  in  1  read clock-enable; advances both read pipeline stages
- rd_data  out  W*P  read word

## Operation
- Two states, defined in the package: FILL and FULL.
- **FILL**
  - data_in_ready=1; tensor_done=0.
  - A beat transfers when data_in_valid && data_in_ready: word written at address wr_cnt, wr_cnt increments.
  - On the transfer with wr_cnt==IN_DEPTH-1: wr_cnt wraps to 0, state goes to FULL.
  - release is ignored in FILL, including when it coincides with the last beat.
- **FULL**
  - data_in_ready=0; tensor_done=1.
  - data_in_valid is ignored; no writes occur.
  - release=1 → state FILL next cycle with wr_cnt=0.
- **Read port**
  - Active in both states; content is only guaranteed in FULL.
  - Read-first on same-address collision: returns the old word.
  - rd_addr ≥ IN_DEPTH returns an undefined word and must not disturb state.
- **Reset (rst=0 asynchronously)**
  - state=FILL, wr_cnt=0, tensor_done=0, rd_data=0.
  - data_in_ready forced 0 until the synchronised reset deasserts.
  - Buffer contents are not cleared.
  - Reset mid-fill discards progress; the next tensor restarts at address 0.

## Timing
- Write: one beat per cycle sustained; there are no bubbles while valid is held in FILL.
- tensor_done rises the cycle after the last beat's transfer edge.
- data_in_ready falls in the same cycle tensor_done rises.
- release → data_in_ready=1 and tensor_done=0 on the next cycle.
- Minimum turnaround (last beat to next accepted beat) is 2 cycles.
- Read latency: 2 rd_ce-qualified edges (addr → stage0 → rd_data). With rd_ce=0 both stages hold.
- data_in_ready depends only on registered state, not combinationally on data_in_valid.

## Structure
- Package weight_stream_sink_pkg:
  - state enum (FILL, FULL)
  - function for the $clog2(depth)+1 address width
- Sub-module weight_sink_ram: simple dual-port, one write port plus one read port with the 2-stage ce-gated output register, depth IN_DEPTH, width W*P.
- Top level: reset synchroniser, FSM, wr_cnt, beat packing.

## Test plan
- **Fill and read back.** Defaults (IN_DEPTH=32, P=1). Stream values 0x0100+i, i=0..31, valid held high.
  - All accepted in 32 cycles; tensor_done=1 on cycle 33.
  - Reading addr 5 with rd_ce=1 gives rd_data=0x0105 two cycles later.
- **Backpressure in FULL.** After the fill, hold valid with data 0xDEAD for 10 cycles.
  - ready=0 throughout; all reads still return the original 0x0100+i.
- **Release and refill.** Pulse release, then stream 0x0200+i.
  - ready=1 the cycle after release; addr 0 reads 0x0200; tensor_done re-asserts after 32 beats.
- **Gapped valid.** Valid toggles 1,0,1,0 during the fill.
  - wr_cnt advances only on transfers; tensor_done only after the 32nd transfer; contents are correct.
- **Simultaneous last beat and release.** Assert release on the same cycle as beat 31.
  - State goes to FULL, tensor_done=1, release ignored.
- **Async reset mid-fill.** Drop rst after 10 beats.
  - ready and tensor_done go 0 immediately.
  - After deassert and 2 sync cycles ready=1; the next beat 0x0300 lands at address 0.
- **Parallel pack.** PAR_0=4, DIM_0=32 (IN_DEPTH=8). Beat 0 carries elements {1,2,3,4}.
  - Word 0 reads 0x0004_0003_0002_0001.

Source files
------------

// File: rtl/weight_stream_sink_pkg.sv
// Shared types and helpers for the weight stream sink.
package weight_stream_sink_pkg;

   // The sink is either accepting beats or holding a complete tensor.
   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } sink_state_t;

   // Read-address width: one extra bit so out-of-range addresses are expressible.
   function automatic int addr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/weight_stream_sink_if.sv
// Valid/ready beat stream carrying P elements of W bits each.
// Element j of a beat sits at bits [W*j+W-1:W*j] of the flattened word.
interface weight_stream_sink_if
   import weight_stream_sink_pkg::*;
#(
   parameter int W = 16,
   parameter int P = 1
) ();

   logic [P-1:0][W-1:0] data_in;
   logic                data_in_valid;
   logic                data_in_ready;

   modport master (
      output data_in,
      output data_in_valid,
      input  data_in_ready
   );

   modport slave (
      input  data_in,
      input  data_in_valid,
      output data_in_ready
   );

endinterface

// File: rtl/weight_sink_ram.sv
// Simple dual-port tensor buffer: one write port, one read port whose
// output passes through two clock-enabled registers so it matches the
// timing of the parameter ROMs it can replace.
module weight_sink_ram
   import weight_stream_sink_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WIDTH = 16,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [$clog2(DEPTH)-1:0]  wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [AW-1:0]             rd_addr,
   input  logic                      rd_ce,
   output logic [WIDTH-1:0]          rd_data
);

   localparam int IW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] stage0;
   logic             in_range;

   assign in_range = (rd_addr < AW'(DEPTH));

   // Storage write; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // First read stage: array lookup. Non-blocking update gives read-first
   // behaviour on a same-address collision. Out-of-range reads return zero
   // and touch nothing else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage0 <= '0;
      end else if (rd_ce) begin
         stage0 <= in_range ? mem[rd_addr[IW-1:0]] : '0;
      end
   end

   // Second read stage: output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_ce) begin
         rd_data <= stage0;
      end
   end

endmodule

// File: rtl/weight_stream_sink.sv
// Receiving end of the weight-source stream. Lands one tensor in a local
// buffer beat by beat, raises tensor_done once the last beat is stored and
// holds off further beats until the consumer releases the buffer.
module weight_stream_sink
   import weight_stream_sink_pkg::*;
#(
   parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
   parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 1,
   parameter int WEIGHT_PRECISION_0       = 16,
   parameter int WEIGHT_PRECISION_1       = 3,
   parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
   parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
   parameter int IN_DEPTH = (WEIGHT_TENSOR_SIZE_DIM_0 * WEIGHT_TENSOR_SIZE_DIM_1) /
                            (WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1)
) (
   input  logic                               clk,
   input  logic                               rst,
   weight_stream_sink_if.slave                s_in,
   input  logic                               tensor_release,
   output logic                               tensor_done,
   input  logic [addr_w(IN_DEPTH)-1:0]        rd_addr,
   input  logic                               rd_ce,
   output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0] rd_data
);

   localparam int P      = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
   localparam int W      = WEIGHT_PRECISION_0;
   localparam int WORD_W = W * P;
   localparam int AW     = addr_w(IN_DEPTH);
   localparam int IW     = $clog2(IN_DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IN_DEPTH - 1);

   // Elaboration-time sanity on the configuration.
   if (IN_DEPTH < 2) begin : g_depth_check
      $error("weight_stream_sink: IN_DEPTH must be at least 2");
   end
   if (WEIGHT_PRECISION_1 > WEIGHT_PRECISION_0) begin : g_frac_check
      $error("weight_stream_sink: fractional bits exceed element width");
   end

   logic [1:0]        rst_sync;
   logic              rst_n_int;
   sink_state_t       state;
   logic [AW-1:0]     wr_cnt;
   logic              ready_q;
   logic              done_q;
   logic              xfer;
   logic [WORD_W-1:0] wr_word;

   // Reset synchroniser: assert immediately, release after two clean edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync[1];

   // Ready comes from registered state only; gating by the synchronised
   // reset keeps the sink closed until reset has fully released.
   assign s_in.data_in_ready = ready_q & rst_n_int;
   assign tensor_done        = done_q;
   assign xfer               = s_in.data_in_valid & s_in.data_in_ready;

   // Beat packing: element j of the beat lands at bits [W*j +: W].
   assign wr_word = s_in.data_in;

   // Fill/full control with registered ready and done flags.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state   <= FILL;
         wr_cnt  <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               // Release is meaningless while filling, even on the last beat.
               if (xfer) begin
                  if (wr_cnt == LAST_ADDR) begin
                     wr_cnt  <= '0;
                     state   <= FULL;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            FULL: begin
               if (tensor_release) begin
                  wr_cnt  <= '0;
                  state   <= FILL;
                  ready_q <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

   weight_sink_ram #(
      .DEPTH (IN_DEPTH),
      .WIDTH (WORD_W),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n_int),
      .we      (xfer),
      .wr_addr (wr_cnt[IW-1:0]),
      .wr_data (wr_word),
      .rd_addr (rd_addr),
      .rd_ce   (rd_ce),
      .rd_data (rd_data)
   );

endmodule
